// File: rtl/ofm_collector_pkg.sv
// rtl/ofm_collector_pkg.sv - shared constants and types for the OFM collector
package ofm_collector_pkg;

  localparam int OFM_WIDTH  = 14;
  localparam int OFM_OWIDTH = 16;
  localparam int OFM_DEPTH  = 2;
  localparam int SET_W      = $clog2(OFM_DEPTH);
  localparam int COL_W      = $clog2(OFM_WIDTH);

  typedef logic signed [OFM_OWIDTH-1:0] ofm_word_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ofm_collector_eyeriss_if.sv
// rtl/ofm_collector_eyeriss_if.sv - array capture strobes and output word stream
interface ofm_collector_eyeriss_if
  import ofm_collector_pkg::*;
#(
  parameter int WIDTH  = OFM_WIDTH,
  parameter int OWIDTH = OFM_OWIDTH
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]         ofm_vld;
  logic signed [OWIDTH-1:0] ofm [WIDTH];
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OWIDTH-1:0] out_data;
  logic [CW-1:0]            out_col;
  logic                     out_last;
  logic                     overflow;

  modport slave (
    input  ofm_vld, ofm, out_ready,
    output out_valid, out_data, out_col, out_last, overflow
  );

  modport master (
    output ofm_vld, ofm, out_ready,
    input  out_valid, out_data, out_col, out_last, overflow
  );

endinterface

// File: rtl/ofm_set_buf.sv
// rtl/ofm_set_buf.sv - one row-set buffer: WIDTH words, fill mask, full flag
module ofm_set_buf #(
  parameter int WIDTH  = 14,
  parameter int OWIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          wr_en,
  input  logic signed [OWIDTH-1:0]  wr_data [WIDTH],
  input  logic                      clr,
  input  logic [$clog2(WIDTH)-1:0]  rd_col,
  output logic signed [OWIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]          fill,
  output logic                      full
);

  logic signed [OWIDTH-1:0] words [WIDTH];

  // Clear wins over writes; the top never writes a column whose fill bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      for (int w = 0; w < WIDTH; w++) words[w] <= '0;
    end else begin
      for (int w = 0; w < WIDTH; w++) begin
        if (wr_en[w]) words[w] <= wr_data[w];
      end
      if (clr) fill <= '0;
      else     fill <= fill | wr_en;
    end
  end

  assign rd_data = words[rd_col];
  assign full    = &fill;

endmodule

// File: rtl/ofm_collector_eyeriss.sv
// rtl/ofm_collector_eyeriss.sv - collects skewed column outputs into row-sets and streams them out
module ofm_collector_eyeriss
  import ofm_collector_pkg::*;
#(
  parameter int WIDTH  = OFM_WIDTH,
  parameter int OWIDTH = OFM_OWIDTH,
  parameter int DEPTH  = OFM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ofm_collector_eyeriss_if.slave   bus
);

  localparam int SW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_SET = SW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

  rd_state_e                state_q, state_d;
  logic [SW-1:0]            col_ptr [WIDTH];
  logic [SW-1:0]            rd_set, rd_set_d;
  logic [CW-1:0]            rd_col;
  logic [WIDTH-1:0]         fill    [DEPTH];
  logic [WIDTH-1:0]         wr_mask [DEPTH];
  logic signed [OWIDTH-1:0] set_rd_data [DEPTH];
  logic [DEPTH-1:0]         full, clr;
  logic [WIDTH-1:0]         accept, drop;
  logic                     out_valid, hs, hs_last, overflow_q;

  for (genvar s = 0; s < DEPTH; s++) begin : g_set
    ofm_set_buf #(.WIDTH(WIDTH), .OWIDTH(OWIDTH)) u_set (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_mask[s]),
      .wr_data (bus.ofm),
      .clr     (clr[s]),
      .rd_col  (rd_col),
      .rd_data (set_rd_data[s]),
      .fill    (fill[s]),
      .full    (full[s])
    );
  end

  assign out_valid = (state_q == RD_STREAM);
  assign hs        = out_valid & bus.out_ready;
  assign hs_last   = hs & (rd_col == LAST_COL);

  // Captures look at the pre-clear mask, so a word aimed at the set draining this cycle is dropped.
  always_comb begin
    accept = '0;
    drop   = '0;
    for (int s = 0; s < DEPTH; s++) begin
      wr_mask[s] = '0;
      clr[s]     = hs_last && (rd_set == SW'(s));
    end
    for (int w = 0; w < WIDTH; w++) begin
      if (bus.ofm_vld[w]) begin
        if (fill[col_ptr[w]][w]) begin
          drop[w] = 1'b1;
        end else begin
          accept[w]               = 1'b1;
          wr_mask[col_ptr[w]][w]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_set_d = rd_set;
    if (hs_last) rd_set_d = (rd_set == LAST_SET) ? '0 : rd_set + 1'b1;
    state_d = state_q;
    case (state_q)
      RD_IDLE:   if (&(fill[rd_set] | wr_mask[rd_set])) state_d = RD_STREAM;
      RD_STREAM: if (hs_last)
                   state_d = (full[rd_set_d] || &(fill[rd_set_d] | wr_mask[rd_set_d]))
                             ? RD_STREAM : RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      rd_set     <= '0;
      rd_col     <= '0;
      overflow_q <= 1'b0;
      for (int w = 0; w < WIDTH; w++) col_ptr[w] <= '0;
    end else begin
      state_q <= state_d;
      rd_set  <= rd_set_d;
      if (hs_last)  rd_col <= '0;
      else if (hs)  rd_col <= rd_col + 1'b1;
      if (|drop) overflow_q <= 1'b1;
      for (int w = 0; w < WIDTH; w++) begin
        if (accept[w]) col_ptr[w] <= (col_ptr[w] == LAST_SET) ? '0 : col_ptr[w] + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = set_rd_data[rd_set];
  assign bus.out_col   = rd_col;
  assign bus.out_last  = out_valid && (rd_col == LAST_COL);
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ofm_collector_eyeriss.sv
// tb/tb_ofm_collector_eyeriss.sv - self-checking bench for ofm_collector_eyeriss
module tb_ofm_collector_eyeriss;
  import ofm_collector_pkg::*;

  localparam int W  = OFM_WIDTH;
  localparam int OW = OFM_OWIDTH;
  localparam int D  = OFM_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofm_collector_eyeriss_if #(.WIDTH(W), .OWIDTH(OW)) bus ();

  ofm_collector_eyeriss #(.WIDTH(W), .OWIDTH(OW), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: each column keeps the words it has accepted but not yet streamed.
  int colq [W][$];
  int m_col;
  bit m_ovf;
  int log_q [$];
  int log_col [$];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    for (int w = 0; w < W; w++) if (colq[w].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < W; w++) colq[w].delete();
      m_col = 0;
      m_ovf = 1'b0;
    end else begin
      bit hs, last;
      hs   = m_valid() && bus.out_ready;
      last = hs && (m_col == W - 1);
      for (int w = 0; w < W; w++) begin
        if (bus.ofm_vld[w]) begin
          if (colq[w].size() < D) colq[w].push_back(int'(bus.ofm[w]));
          else m_ovf = 1'b1;
        end
      end
      if (last) begin
        for (int w = 0; w < W; w++) void'(colq[w].pop_front());
        m_col = 0;
      end else if (hs) begin
        m_col++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_col", bus.out_col, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_overflow", bus.overflow, 0);
    end else begin
      bit ev;
      ev = m_valid();
      chk("out_valid", bus.out_valid, ev);
      chk("overflow", bus.overflow, m_ovf);
      if (ev) begin
        chk("out_data", bus.out_data, colq[m_col][0]);
        chk("out_col", bus.out_col, m_col);
        chk("out_last", bus.out_last, (m_col == W - 1));
      end else begin
        chk("out_last_idle", bus.out_last, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        log_q.push_back(int'(bus.out_data));
        log_col.push_back(int'(bus.out_col));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [W-1:0] mask);
    bus.ofm_vld = mask;
    step();
    bus.ofm_vld = '0;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_col.delete();
  endtask

  task automatic check_set_log(input string name, input int base, input int stride);
    chk({name, "_count"}, log_q.size(), W);
    for (int i = 0; i < W && i < log_q.size(); i++) begin
      chk({name, "_word"}, log_q[i], base + stride * i);
      chk({name, "_col"}, log_col[i], i);
    end
  endtask

  initial begin
    logic [OW-1:0] d_hold;
    int c_hold;
    bit stalled;
    int hs_count;
    bit found;

    bus.ofm_vld   = '0;
    bus.out_ready = 1'b0;
    for (int w = 0; w < W; w++) bus.ofm[w] = '0;

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Aligned capture
    bus.out_ready = 1'b1;
    clear_log();
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(w * 100 - 700);
    chk("aligned_pre_valid", bus.out_valid, 0);
    pulse('1);
    chk("aligned_first_valid", bus.out_valid, 1);
    repeat (W) step();
    check_set_log("aligned", -700, 100);
    chk("aligned_idle_after", bus.out_valid, 0);

    // Skewed arrival: column w strobes at cycle 10+w
    clear_log();
    repeat (10) step();
    for (int w = 0; w < W; w++) begin
      bus.ofm[w] = OW'(w * 7 - 3);
      pulse(W'(1) << w);
      if (w < W - 1) chk("skew_not_yet_valid", bus.out_valid, 0);
    end
    chk("skew_valid_after_col13", bus.out_valid, 1);
    repeat (W) step();
    check_set_log("skew", -3, 7);

    // Backpressure with ready pattern 1,0,0,1
    clear_log();
    bus.out_ready = 1'b0;
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(300 + w * 11);
    pulse('1);
    hs_count = 0;
    for (int i = 0; i < 80 && log_q.size() < W; i++) begin
      bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
      stalled = bus.out_valid && !bus.out_ready;
      d_hold  = bus.out_data;
      c_hold  = int'(bus.out_col);
      if (bus.out_valid && bus.out_ready) hs_count++;
      step();
      if (stalled) begin
        chk("bp_data_stable", bus.out_data, $signed(d_hold));
        chk("bp_col_stable", bus.out_col, c_hold);
      end
    end
    chk("bp_handshakes", hs_count, W);
    check_set_log("bp", 300, 11);
    step();
    chk("bp_no_extra", log_q.size(), W);

    // Wrap-around: 5 sets, column w strobes set k at cycle 18k + 3w/2
    clear_log();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4 * 18 + 20; c++) begin
      logic [W-1:0] m;
      m = '0;
      for (int k = 0; k < 5; k++) begin
        for (int w = 0; w < W; w++) begin
          if (c == 18 * k + (w * 3) / 2) begin
            m[w] = 1'b1;
            bus.ofm[w] = OW'(k * 1000 + w);
          end
        end
      end
      pulse(m);
    end
    repeat (W + 2) step();
    chk("wrap_count", log_q.size(), 5 * W);
    for (int i = 0; i < log_q.size(); i++) chk("wrap_word", log_q[i], (i / W) * 1000 + (i % W));
    chk("wrap_overflow", bus.overflow, 0);

    // Overflow: two sets held, third word for column 3 dropped
    clear_log();
    bus.out_ready = 1'b0;
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(50 + w);
    pulse('1);
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(-50 - w);
    pulse('1);
    chk("ovf_before", bus.overflow, 0);
    bus.ofm[3] = 16'sh7FFF;
    pulse(W'(1) << 3);
    chk("ovf_set", bus.overflow, 1);
    bus.out_ready = 1'b1;
    repeat (2 * W + 2) step();
    chk("ovf_drain_count", log_q.size(), 2 * W);
    for (int i = 0; i < log_q.size(); i++) chk("ovf_no_7fff", (log_q[i] == 32767), 0);
    chk("ovf_sticky", bus.overflow, 1);

    // Reset clears overflow
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("ovf_cleared", bus.overflow, 0);

    // Capture into the set being cleared on its last handshake
    clear_log();
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(200 + w);
    pulse('1);
    bus.ofm[5] = 16'sd77;
    pulse(W'(1) << 5);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.out_last) found = 1'b1;
      else step();
    end
    chk("clr_found_last", found, 1);
    bus.ofm[5] = 16'sh1234;
    pulse(W'(1) << 5);
    chk("clr_collision_ovf", bus.overflow, 1);
    repeat (4) step();
    for (int i = 0; i < log_q.size(); i++) chk("clr_no_1234", (log_q[i] == 16'h1234), 0);

    // Reset mid-stream at column 6
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(9 * w);
    pulse('1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.out_valid && bus.out_col == 6) found = 1'b1;
      else step();
    end
    chk("mid_found_col6", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_async_valid_drop", bus.out_valid, 0);
    chk("mid_async_col", bus.out_col, 0);
    step();
    rst_n = 1'b1;
    step();
    clear_log();
    for (int w = 0; w < W; w++) bus.ofm[w] = OW'(w - 5);
    pulse('1);
    repeat (W + 1) step();
    check_set_log("post_reset", -5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ofm_collector_eyeriss.md
# ofm_collector_eyeriss

Output collection stage placed directly downstream of the Eyeriss-style unary-temporal systolic array. It captures each column's finished partial-sum word from the array's top-row `ofm` outputs, which arrive skewed in time across columns. It holds up to DEPTH complete output row-sets and serializes each completed set, column 0 first, onto a single valid/ready stream toward the output SRAM writer.

## Interface
Parameters:
- `WIDTH`, 14: number of array columns, i.e. words per row-set.
- `OWIDTH`, 16: signed output word width, matching the array.
- `DEPTH`, 2: number of row-set buffers; must be at least 2.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ofm_vld`, in, [WIDTH-1:0]: per-column capture strobe, one-cycle pulse per finished word.
- `ofm`, in, signed [OWIDTH-1:0] × [WIDTH-1:0]: array column outputs; column w is sampled when `ofm_vld[w]` is high.
- `out_valid`, out, 1: stream word valid.
- `out_ready`, in, 1: stream consumer ready.
- `out_data`, out, signed [OWIDTH-1:0]: stream word.
- `out_col`, out, $clog2(WIDTH): column index of `out_data`.
- `out_last`, out, 1: high when `out_col == WIDTH-1` while `out_valid` is high.
- `overflow`, out, 1: sticky drop flag, cleared only by reset.

## Operation
- Storage: `buf[DEPTH][WIDTH]` words, plus `fill[DEPTH]` WIDTH-bit masks.
- Per-column write pointers `col_ptr[w]`, range 0..DEPTH-1. Read pointers `rd_set` and `rd_col`.
- Capture, column w, when `ofm_vld[w]` is high:
  - Target set is `s = col_ptr[w]`.
  - If `fill[s][w] == 0`: write `buf[s][w] <= ofm[w]`, set `fill[s][w]`, and advance `col_ptr[w]` modulo DEPTH (wraps from DEPTH-1 to 0).
  - Otherwise drop the word and set `overflow`. `col_ptr[w]` does not move.
- Columns advance independently, so a fast column may begin filling set s+1 before slower columns finish set s.
- Set s is complete when `fill[s]` is all ones.
- Read path:
  - `out_valid = complete(rd_set)`.
  - `out_data = buf[rd_set][rd_col]`, `out_col = rd_col`.
  - On handshake (`out_valid & out_ready`), `rd_col` increments.
  - On the handshake with `out_last` high: `rd_col <= 0`, `fill[rd_set] <= 0`, and `rd_set` advances modulo DEPTH.
- Simultaneous events:
  - A capture that targets the set being cleared in the same cycle sees the pre-clear mask. It is dropped and sets `overflow`.
  - Captures to different sets, or to different columns of the same set, in one cycle are all accepted.
- Data is stored unmodified: no saturation or sign manipulation.
- `out_data` and `out_col` are held stable while `out_valid` is high and `out_ready` is low.

## Timing
- Reset values: all `fill` bits 0, all `col_ptr` 0, `rd_set`/`rd_col` 0, `buf` 0, `overflow` 0.
- Outputs during reset: `out_valid` 0, `out_data` 0, `out_col` 0, `out_last` 0.
- Capture latency: a strobe in cycle t is registered at the t+1 edge. If that strobe completes the set, `out_valid` is high in cycle t+1.
- Stream throughput: one word per cycle while `out_ready` is high, so a set drains in WIDTH cycles minimum.
- Back-to-back sets: if set rd_set+1 is already complete, `out_valid` stays high across the set boundary with no bubble.
- `out_valid` is derived combinationally from registered state only; there is no combinational path from `out_ready` to `out_valid`.
- Mid-operation reset: asynchronously discards all buffered and partial sets. `overflow` clears.

## Structure
- Shared package `ofm_collector_pkg`:
  - `SET_W = $clog2(DEPTH)` and `COL_W = $clog2(WIDTH)` localparams.
  - Typedef for the signed OWIDTH word.
- One sub-module, `ofm_set_buf`: storage for one row-set, containing the WIDTH words, the fill mask, per-column write, a full flag, and a synchronous clear.
  - The top instantiates DEPTH copies of it.
  - The top holds the `col_ptr` array, the read FSM and the overflow logic.
- Read FSM has two states:
  - IDLE: current set incomplete.
  - STREAM: `out_valid` high.
  - STREAM returns to IDLE after the last handshake unless the next set is already complete.

## Test plan
- Aligned capture: all 14 `ofm_vld` pulse in one cycle with `ofm[w] = w*100 - 700`; `out_ready` held at 1. Required: 14 consecutive words -700, -600, …, 600; `out_last` set only on col 13; `out_valid` first high the cycle after the strobe.
- Skewed arrival: `ofm_vld[w]` pulses at cycle 10+w. Required: `out_valid` stays 0 until cycle 24 (one cycle after the col-13 strobe), then streams col 0..13.
- Backpressure: complete a set, then toggle `out_ready` 1,0,0,1,… Required: `out_data`/`out_col` stable during stalls, no word lost or duplicated, exactly 14 handshakes.
- Wrap-around: stream 5 sets with DEPTH=2 and `out_ready=1`; column 0 runs two sets ahead of column 13 without exceeding DEPTH. Required: all 70 words in order; `col_ptr` wraps 1→0; `overflow` stays 0.
- Overflow: hold `out_ready=0`, fill 2 sets, then pulse `ofm_vld[3]` with value 0x7FFF. Required: `overflow` is 1 from the next cycle and 0x7FFF never appears on the stream. Also, a capture to the set being cleared, issued in the same cycle as its `out_last` handshake, is dropped with `overflow` set.
- Reset mid-stream: assert `rst_n=0` while streaming col 6 of a set. Required: `out_valid` drops to 0 asynchronously, and a subsequent full set streams from col 0 with correct data.
